ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameters: DEPTH, 4, queue entries (power of 2, >=2); RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 SHALL have ports: CK  in  1  clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 MA  out  16  instruction-memory word address of the current request.
REQ-005 MREQ  out  1  fetch request strobe, one cycle per request.
REQ-006 MD  in  16  instruction word from memory, sampled only when MACK=1.
REQ-007 MACK  in  1  memory response for the single outstanding request.
REQ-008 ID  out  16  instruction word at queue head, to CPU.
REQ-009 IPC  out  16  address of the word on ID.
REQ-010 IVAL  out  1  ID/IPC valid.
REQ-011 IRDY  in  1  CPU consumes head when IVAL=1 and IRDY=1.
REQ-012 JMP  in  1  redirect: flush queue and restart fetch at JA.
REQ-013 JA  in  16  redirect target, sampled when JMP=1.

Function
REQ-014 SHALL hold a FIFO of DEPTH {word, address} entries, count 0..DEPTH, fetch-PC register FPC, and FSM states IDLE, WAIT, DROP.
REQ-015 SHALL drive MREQ combinationally = (state==IDLE && count<DEPTH && JMP==0); MA = FPC.
REQ-016 On an edge with MREQ=1: state->WAIT, FPC->FPC+1 mod 2^16 (16'hFFFF wraps to 16'h0000).
REQ-017 In WAIT with MACK=1 and JMP=0: push {MD, requested address}, state->IDLE.
REQ-018 MACK SHALL be ignored in IDLE; at most one request SHALL be outstanding at any time.
REQ-019 IVAL = (count!=0); ID/IPC = head entry when IVAL=1, 16'h0000 when IVAL=0.
REQ-020 Pop on edge with IVAL=1 and IRDY=1 and JMP=0; push and pop in the same cycle leave count unchanged.
REQ-021 Latency: MREQ in cycle N, MACK in cycle N+k (k>=1) -> IVAL=1 in cycle N+k+1; peak throughput one word per 2 cycles.
REQ-022 JMP=1 on an edge: count->0, FPC->JA, any same-cycle pop or push discarded; IDLE stays IDLE; WAIT->DROP.
REQ-023 In DROP: MREQ=0; next MACK discarded and state->IDLE; JMP in DROP updates FPC only and remains in DROP.
REQ-024 With JMP=1 in WAIT and MACK=1 in the same cycle: response discarded, state->IDLE (not DROP).
REQ-025 With count==DEPTH: MREQ=0, no push possible; fetch resumes in the cycle after a pop.
REQ-026 Pointers SHALL wrap modulo DEPTH; no entry is overwritten or read twice.

Reset
REQ-027 With RST=0, immediately and without a clock: state=IDLE, count=0, FPC=RESET_PC, IVAL=0, ID=0, IPC=0.
REQ-028 While RST=0, MREQ=0 irrespective of state.
REQ-029 With RST asserted mid-request, the outstanding response SHALL be ignored (state is IDLE after reset).
REQ-030 The first MREQ after release SHALL occur in the first cycle with RST=1, with MA=RESET_PC.

Verification
REQ-031 Reset release, memory with 1-cycle MACK returning MD=MA^16'hA5A5, IRDY=1 -> ID/IPC sequence (A5A5,0),(A5A4,1),(A5A7,2), one word per 2 cycles.
REQ-032 IRDY=0 held -> 4 pushes, then MREQ stays 0 with count=4; single IRDY pulse -> exactly one pop, one new MREQ with MA=4.
REQ-033 JMP=1 with JA=16'h0040 while WAIT, MACK 3 cycles later -> that response dropped, IVAL=0, next MREQ with MA=16'h0040, first ID has IPC=16'h0040.
REQ-034 JMP coincident with MACK and IRDY, count=2 -> count=0, IVAL=0 next cycle, next MA=JA.
REQ-035 JA=16'hFFFE, IRDY=1 -> IPC sequence FFFE, FFFF, 0000, 0001.
REQ-036 RST=0 asserted in WAIT, MACK asserted during and after reset -> no push, IVAL=0; first MREQ after release has MA=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: single-outstanding memory fetcher feeding a
// DEPTH-entry {word, address} FIFO, with redirect (JMP) flush and response drop.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  output logic [15:0] MA,
  output logic        MREQ,
  input  logic [15:0] MD,
  input  logic        MACK,
  output logic [15:0] ID,
  output logic [15:0] IPC,
  output logic        IVAL,
  input  logic        IRDY,
  input  logic        JMP,
  input  logic [15:0] JA
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [15:0]     fpc_q, fpc_d;
  logic [15:0]     data_q [DEPTH];
  logic [15:0]     addr_q [DEPTH];

  logic push, pop;

  assign IVAL = (count_q != '0);
  assign ID   = IVAL ? data_q[rd_q] : '0;
  assign IPC  = IVAL ? addr_q[rd_q] : '0;
  assign MA   = fpc_q;
  assign MREQ = RST && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !JMP;
  assign push = (state_q == WAIT) && MACK && !JMP;
  assign pop  = IVAL && IRDY && !JMP;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fpc_d   = fpc_q;
    if (JMP) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      fpc_d   = JA;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (MREQ) fpc_d = fpc_q + 16'd1;
    end
    case (state_q)
      IDLE: if (MREQ) state_d = WAIT;
      // A redirect that coincides with the response consumes it, so no DROP.
      WAIT: begin
        if (JMP)       state_d = MACK ? IDLE : DROP;
        else if (MACK) state_d = IDLE;
      end
      DROP: if (MACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fpc_q   <= fpc_d;
    end
  end

  // Requested address is FPC-1: FPC only moves on a request or a redirect,
  // and a redirect while waiting prevents the push.
  always_ff @(posedge CK) begin
    if (push) begin
      data_q[wr_q] <= MD;
      addr_q[wr_q] <= fpc_q - 16'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: vector table for the basic fetch stream,
// plus hand sequences with a latency-programmable memory responder.
module tb_ifetch_queue;

  logic        CK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] MA, MD = '0, ID, IPC, JA = '0;
  logic        MREQ, MACK = 1'b0, IVAL, IRDY = 1'b0, JMP = 1'b0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .CK(CK), .RST(RST), .MA(MA), .MREQ(MREQ), .MD(MD), .MACK(MACK),
    .ID(ID), .IPC(IPC), .IVAL(IVAL), .IRDY(IRDY), .JMP(JMP), .JA(JA)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int failures = 0;

  logic        o_mreq, o_ival;
  logic [15:0] o_ma, o_id, o_ipc;
  logic        pend = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [15:0] paddr = '0;

  typedef struct {
    logic rst, mack; logic [15:0] md; logic irdy, jmp; logic [15:0] ja;
    logic e_mreq; logic [15:0] e_ma; logic e_ival; logic [15:0] e_id, e_ipc;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the memory model answering MREQ after 'lat' cycles.
  task automatic cyc(input logic rst, input logic irdy, input logic jmp,
                     input logic [15:0] ja, input logic xmack);
    logic m;
    m = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin m = 1'b1; pend = 1'b0; end
    end
    RST = rst; IRDY = irdy; JMP = jmp; JA = ja;
    MACK = m | xmack; MD = paddr ^ 16'hA5A5;
    #3;
    o_mreq = MREQ; o_ma = MA; o_ival = IVAL; o_id = ID; o_ipc = IPC;
    if (MREQ) begin pend = 1'b1; cnt = lat; paddr = MA; end
    @(posedge CK); #1;
  endtask

  task automatic reset_dut(input int l);
    pend = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    pend = 1'b0;
    lat = l;
  endtask

  logic [15:0] exp_a [5];
  int got;

  initial begin
    tv[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tv[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tv[2] = '{1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    tv[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b1, 16'hA5A5, 16'h0000};
    tv[4] = '{1'b1, 1'b1, 16'hA5A4, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    tv[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0002, 1'b1, 16'hA5A4, 16'h0001};
    tv[6] = '{1'b1, 1'b1, 16'hA5A7, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0003, 1'b0, 16'h0000, 16'h0000};
    tv[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b1, 16'hA5A7, 16'h0002};

    for (int i = 0; i < 8; i++) begin
      RST = tv[i].rst; MACK = tv[i].mack; MD = tv[i].md;
      IRDY = tv[i].irdy; JMP = tv[i].jmp; JA = tv[i].ja;
      #3;
      chk($sformatf("vec%0d_mreq", i), MREQ, tv[i].e_mreq);
      chk($sformatf("vec%0d_ma", i),   MA,   tv[i].e_ma);
      chk($sformatf("vec%0d_ival", i), IVAL, tv[i].e_ival);
      chk($sformatf("vec%0d_id", i),   ID,   tv[i].e_id);
      chk($sformatf("vec%0d_ipc", i),  IPC,  tv[i].e_ipc);
      @(posedge CK); #1;
    end

    // Fill to full with IRDY low, then a single pop.
    reset_dut(1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("full_mreq", o_mreq, 1'b0);
      chk("full_ipc", o_ipc, 16'h0000);
    end
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("pulse_mreq", o_mreq, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("resume_mreq", o_mreq, 1'b1);
    chk("resume_ma", o_ma, 16'h0004);
    chk("one_pop_ipc", o_ipc, 16'h0001);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("refill_mreq_a", o_mreq, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("refill_mreq_b", o_mreq, 1'b0);
    chk("refill_ipc", o_ipc, 16'h0001);
    exp_a = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    got = 0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      if (o_ival) begin
        chk($sformatf("drain_ipc%0d", got), o_ipc, exp_a[got]);
        chk($sformatf("drain_id%0d", got), o_id, exp_a[got] ^ 16'hA5A5);
        got++;
      end
    end
    chk("drain_count", 16'(got), 16'd5);

    // Redirect while waiting; late response must be dropped.
    reset_dut(3);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_req_ma", o_ma, 16'h0000);
    cyc(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
    chk("drop_jmp_mreq", o_mreq, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_state_mreq", o_mreq, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_mack_mreq", o_mreq, 1'b0);
    chk("drop_mack_ival", o_ival, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_next_mreq", o_mreq, 1'b1);
    chk("drop_next_ma", o_ma, 16'h0040);
    chk("drop_next_ival", o_ival, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_wait_ival", o_ival, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_first_ival", o_ival, 1'b1);
    chk("drop_first_ipc", o_ipc, 16'h0040);
    chk("drop_first_id", o_id, 16'hA5E5);

    // JMP coincident with MACK and IRDY while holding two entries.
    reset_dut(1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
    chk("coinc_ival_before", o_ival, 1'b1);
    chk("coinc_mreq", o_mreq, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("coinc_ival_after", o_ival, 1'b0);
    chk("coinc_id_after", o_id, 16'h0000);
    chk("coinc_ipc_after", o_ipc, 16'h0000);
    chk("coinc_mreq_after", o_mreq, 1'b1);
    chk("coinc_ma_after", o_ma, 16'h1234);

    // Address wrap through 16'hFFFF.
    reset_dut(1);
    cyc(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
    got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      if (o_ival) begin
        chk($sformatf("wrap_ipc%0d", got), o_ipc, exp_a[got]);
        got++;
      end
    end
    chk("wrap_count", 16'(got), 16'd4);

    // Reset asserted while a request is outstanding.
    reset_dut(2);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rstw_mreq", o_mreq, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rstw_async_mreq", o_mreq, 1'b0);
    chk("rstw_async_ma", o_ma, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rstw_hold_ival", o_ival, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rstw_rel_mreq", o_mreq, 1'b1);
    chk("rstw_rel_ma", o_ma, 16'h0000);
    chk("rstw_rel_ival", o_ival, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rstw_nopush_ival", o_ival, 1'b0);
    chk("rstw_wait_mreq", o_mreq, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rstw_first_ival", o_ival, 1'b1);
    chk("rstw_first_ipc", o_ipc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
